irrigation_event_receiver: RTL and testbench
============================================

# irrigation_event_receiver

Controller-side receiver for the field comparator's event stream. Each sample carries one event bit and a 3-bit Gray-coded sensor-participation flag. The block decodes and validates every sample, and requires a run of consistent positive samples before it opens the irrigation valve. It also bounds valve-on time, enforces a hold-off interval between irrigation cycles and keeps a saturating irrigation-event counter.

## Interface
- CONFIRM_CNT, 4: consecutive trusted positive samples needed to open the valve; legal range 2..15.
- IRRIGATE_CYCLES, 1000: maximum number of valve-open clock cycles; must be at least 1.
- HOLDOFF_CYCLES, 200: number of cycles input is refused after irrigation ends; must be at least 1.
- CNT_W, 16: timer width; must hold max(IRRIGATE_CYCLES, HOLDOFF_CYCLES).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample present on event_in / flag_in.
- in_ready  out  1  block accepts the sample; a transfer occurs when in_valid && in_ready.
- event_in  in  1  comparator event bit.
- flag_in  in  3  Gray-coded participation flag.
- valve_open  out  1  irrigation valve drive.
- active_sensors  out  3  binary decode of the last accepted flag.
- state  out  2  FSM state: IDLE=0, CONFIRM=1, IRRIGATE=2, HOLDOFF=3.
- err_flag  out  1  one-cycle pulse when an accepted sample is rejected as untrusted.
- evt_count  out  8  number of IRRIGATE entries, saturating at 255.

## Operation
- Gray decode: b2=g2; b1=g2^g1; b0=b1^g0. active_sensors is registered on every accepted sample.
- Trusted positive sample: event_in=1 and decoded flag != 0.
- Untrusted sample: event_in=1 with flag 0, or event_in=0 with flag != 0. Either case pulses err_flag.
- Negative sample: event_in=0 and flag 0.
- IDLE:
  - Trusted positive sample → CONFIRM, with conf_cnt=1.
  - Any other accepted sample → stay in IDLE.
- CONFIRM:
  - Trusted positive sample → conf_cnt+1. When conf_cnt reaches CONFIRM_CNT → IRRIGATE.
  - Negative or untrusted sample → IDLE, with conf_cnt=0.
  - Cycles with no transfer hold conf_cnt.
- IRRIGATE:
  - valve_open=1. The timer loads IRRIGATE_CYCLES-1 on entry and decrements every cycle.
  - Timer reaching 0 → HOLDOFF.
  - Accepted negative sample → HOLDOFF early.
  - Positive and untrusted samples are consumed without effect, except for the err_flag pulse.
- HOLDOFF:
  - in_ready=0. The timer loads HOLDOFF_CYCLES-1 on entry.
  - Timer reaching 0 → IDLE.
- in_ready=1 in IDLE, CONFIRM and IRRIGATE.
- evt_count increments on each entry to IRRIGATE and holds at 255.

## Timing
- Reset values: valve_open=0, in_ready=1, state=IDLE, active_sensors=0, err_flag=0, evt_count=0. conf_cnt and the timer also reset to 0.
- Reset asserted mid-irrigation drops valve_open asynchronously.
- All outputs are registered, except in_ready, which is decoded combinationally from state.
- The accepted sample that completes confirmation is followed by valve_open=1 on the next clock edge.
- Valve-on duration:
  - Exactly IRRIGATE_CYCLES cycles if no negative sample arrives.
  - If a negative sample is accepted in IRRIGATE cycle k (1-based), valve_open falls after cycle k.
- HOLDOFF lasts exactly HOLDOFF_CYCLES cycles. in_ready rises in the first IDLE cycle.
- Timer expiry and an accepted negative sample in the same cycle are a single transition to HOLDOFF; the timer is not double-counted.
- err_flag is high for exactly one cycle: the cycle after the offending transfer.

## Configuration
- GRAY_ADJ_CHECK_EN defined:
  - Each accepted flag is compared with the previously accepted flag.
  - A Hamming distance greater than 1 marks the sample untrusted, with the untrusted consequences above (CONFIRM → IDLE, err_flag pulse).
  - The first sample after reset is exempt.
- Not defined: no adjacency check; trust depends only on event/flag consistency.

## Test plan
- Reset, then four accepted samples of event=1, flag=3'b001 (CONFIRM_CNT=4) → state 0→1→1→1→2; valve_open=1 the cycle after the fourth transfer; evt_count=1; active_sensors=1.
- Valve opened, no further input (IRRIGATE_CYCLES=1000, HOLDOFF_CYCLES=200) → valve_open high for exactly 1000 cycles; in_ready low for exactly 200 cycles; state returns to 0.
- In CONFIRM with conf_cnt=2, send event=1, flag=0 → err_flag pulses once; state=IDLE; a subsequent valid run needs four fresh samples.
- In IRRIGATE, send event=0, flag=0 at cycle 10 → valve_open falls after cycle 10; state=HOLDOFF.
- With GRAY_ADJ_CHECK_EN, send flags 3'b001 then 3'b111, both event=1 → err_flag pulses; state returns to IDLE. Without the macro, state advances to CONFIRM with conf_cnt=2.
- Assert rst during IRRIGATE cycle 50, and drive 300 irrigation cycles with short timers → valve_open=0 immediately and all outputs take reset values; evt_count saturates at 255.

Source files
------------

// File: rtl/irrigation_event_receiver.sv
// irrigation_event_receiver: validates Gray-flagged comparator samples and drives the confirm/irrigate/hold-off valve cycle.
// Optional build macro GRAY_ADJ_CHECK_EN: a sample whose flag differs from the previously accepted flag in more than one bit is untrusted.
module irrigation_event_receiver #(
  parameter int CONFIRM_CNT     = 4,
  parameter int IRRIGATE_CYCLES = 1000,
  parameter int HOLDOFF_CYCLES  = 200,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       event_in,
  input  logic [2:0] flag_in,
  output logic       valve_open,
  output logic [2:0] active_sensors,
  output logic [1:0] state,
  output logic       err_flag,
  output logic [7:0] evt_count
);
  typedef enum logic [1:0] {IDLE = 2'd0, CONFIRM = 2'd1, IRRIGATE = 2'd2, HOLDOFF = 2'd3} state_t;
  state_t           state_q, state_d;
  logic [3:0]       conf_q, conf_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             valve_q, err_q;
  logic [2:0]       sens_q;
  logic [7:0]       evt_q;
  logic [2:0]       bin;
  logic             xfer, far, pos, neg;
  assign bin      = {flag_in[2], flag_in[2] ^ flag_in[1], flag_in[2] ^ flag_in[1] ^ flag_in[0]};
  assign in_ready = state_q != HOLDOFF;
  assign xfer     = in_valid && in_ready;
`ifdef GRAY_ADJ_CHECK_EN
  logic [2:0] prev_q;
  logic       seen_q;
  assign far = seen_q && ($countones(prev_q ^ flag_in) > 1);
  // remember the last accepted raw flag; the first sample after reset has nothing to compare against
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prev_q <= 3'd0;
      seen_q <= 1'b0;
    end else if (xfer) begin
      prev_q <= flag_in;
      seen_q <= 1'b1;
    end
`else
  assign far = 1'b0;
`endif
  assign pos = event_in && bin != 3'd0 && !far;
  assign neg = !event_in && bin == 3'd0 && !far;
  // next-state: confirmation run, bounded irrigation and hold-off, sharing one down-counter
  always_comb begin
    state_d = state_q;
    conf_d  = conf_q;
    timer_d = timer_q == '0 ? timer_q : timer_q - CNT_W'(1);
    case (state_q)
      IDLE:
        if (xfer && pos) begin
          state_d = CONFIRM;
          conf_d  = 4'd1;
        end
      CONFIRM:
        if (xfer) begin
          if (!pos) begin
            state_d = IDLE;
            conf_d  = 4'd0;
          end else if (conf_q + 4'd1 == 4'(CONFIRM_CNT)) begin
            state_d = IRRIGATE;
            conf_d  = 4'd0;
            timer_d = CNT_W'(IRRIGATE_CYCLES - 1);
          end else conf_d = conf_q + 4'd1;
        end
      IRRIGATE:
        if (timer_q == '0 || (xfer && neg)) begin
          state_d = HOLDOFF;
          timer_d = CNT_W'(HOLDOFF_CYCLES - 1);
        end
      default:
        if (timer_q == '0) state_d = IDLE;
    endcase
  end
  // FSM state, confirmation count and phase timer
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      conf_q  <= 4'd0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      conf_q  <= conf_d;
      timer_q <= timer_d;
    end
  // registered outputs: valve follows the next state so it opens right after the confirming edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valve_q <= 1'b0;
      err_q   <= 1'b0;
      sens_q  <= 3'd0;
      evt_q   <= 8'd0;
    end else begin
      valve_q <= state_d == IRRIGATE;
      err_q   <= xfer && !pos && !neg;
      sens_q  <= xfer ? bin : sens_q;
      evt_q   <= (state_d == IRRIGATE && state_q != IRRIGATE && evt_q != 8'hFF) ? evt_q + 8'd1 : evt_q;
    end
  assign valve_open     = valve_q;
  assign err_flag       = err_q;
  assign active_sensors = sens_q;
  assign evt_count      = evt_q;
  assign state          = state_q;
endmodule

// File: tb/tb_irrigation_event_receiver.sv
// tb_irrigation_event_receiver: randomized and directed checks of the event receiver against a remaining-time reference model.
module tb_irrigation_event_receiver;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, event_in = 1'b0;
  logic [2:0] flag_in = 3'd0;
  logic in_ready, valve_open, err_flag, s_ready, s_valve, s_err;
  logic [2:0] active_sensors, s_sens;
  logic [1:0] state, s_state;
  logic [7:0] evt_count, s_evt;
  logic [15:0] dvec, svec;
  int checks = 0, failures = 0;
  typedef struct {int st, run, left, sens, err, evt, prev, seen, c, irr, hold;} mdl_t;
  mdl_t m, ms;
  always #5 clk = ~clk;
  irrigation_event_receiver dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .event_in(event_in),
    .flag_in(flag_in), .valve_open(valve_open), .active_sensors(active_sensors), .state(state), .err_flag(err_flag), .evt_count(evt_count));
  irrigation_event_receiver #(.CONFIRM_CNT(2), .IRRIGATE_CYCLES(3), .HOLDOFF_CYCLES(2)) dut_s (.clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(s_ready), .event_in(event_in), .flag_in(flag_in), .valve_open(s_valve),
    .active_sensors(s_sens), .state(s_state), .err_flag(s_err), .evt_count(s_evt));
  assign dvec = {valve_open, in_ready, state, active_sensors, err_flag, evt_count};
  assign svec = {s_valve, s_ready, s_state, s_sens, s_err, s_evt};
  function automatic mdl_t mreset(int c, int irr, int hold);
    mdl_t r = '{default: 0};
    r.c = c; r.irr = irr; r.hold = hold;
    return r;
  endfunction
  // one clock of the specification's rules; left counts the cycles still to spend in the current timed phase
  function automatic mdl_t step(mdl_t mi, bit v, bit e, logic [2:0] f);
    mdl_t r = mi;
    int g = int'(f);
    int b = g ^ (g >> 1) ^ (g >> 2);
    int d = r.prev ^ g;
    bit far = 1'b0, x, p, n;
`ifdef GRAY_ADJ_CHECK_EN
    far = r.seen != 0 && d != 0 && (d & (d - 1)) != 0;
`endif
    x = v && r.st != 3;
    p = e && b != 0 && !far;
    n = !e && b == 0 && !far;
    r.err = (x && !p && !n) ? 1 : 0;
    if (x) begin r.sens = b; r.prev = g; r.seen = 1; end
    case (r.st)
      0: if (x && p) begin r.st = 1; r.run = 1; end
      1: if (x) begin
           if (!p) begin r.st = 0; r.run = 0; end
           else begin
             r.run++;
             if (r.run == r.c) begin r.st = 2; r.run = 0; r.left = r.irr; if (r.evt < 255) r.evt++; end
           end
         end
      2: begin r.left--; if (r.left == 0 || (x && n)) begin r.st = 3; r.left = r.hold; end end
      default: begin r.left--; if (r.left == 0) r.st = 0; end
    endcase
    return r;
  endfunction
  function automatic logic [15:0] ev(mdl_t r);
    return {r.st == 2, r.st != 3, 2'(r.st), 3'(r.sens), r.err[0], 8'(r.evt)};
  endfunction
  task automatic tick(input bit v, input bit e, input logic [2:0] f);
    in_valid = v; event_in = e; flag_in = f;
    m = step(m, v, e, f);
    ms = step(ms, v, e, f);
    @(posedge clk); #1;
  endtask
  task automatic apply_reset();
    rst = 1'b1; in_valid = 1'b0; event_in = 1'b0; flag_in = 3'd0;
    m = mreset(4, 1000, 200);
    ms = mreset(2, 3, 2);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic test_reset();
    apply_reset();
    checks++; if (dvec !== 16'h4000) begin failures++; $display("FAIL reset_main: got %h want %h", dvec, 16'h4000); end
    checks++; if (svec !== ev(ms)) begin failures++; $display("FAIL reset_short: got %h want %h", svec, ev(ms)); end
  endtask
  task automatic test_confirm();
    logic [1:0] want [4] = '{2'd1, 2'd1, 2'd1, 2'd2};
    for (int i = 0; i < 4; i++) begin
      tick(1, 1, 3'b001);
      checks++; if (state !== want[i]) begin failures++; $display("FAIL confirm_state%0d: got %0d want %0d", i, state, want[i]); end
    end
    checks++; if ({valve_open, evt_count, active_sensors} !== {1'b1, 8'd1, 3'd1}) begin
      failures++; $display("FAIL confirm_open: got v=%b e=%0d s=%0d want v=1 e=1 s=1", valve_open, evt_count, active_sensors); end
    checks++; if (dvec !== ev(m)) begin failures++; $display("FAIL confirm_model: got %h want %h", dvec, ev(m)); end
  endtask
  task automatic test_full_cycle();
    int on = 0, off = 0, n = 0;
    while (valve_open === 1'b1 && n < 1100) begin on++; n++; tick(0, 0, 3'd0); end
    checks++; if (on != 1000) begin failures++; $display("FAIL valve_duration: got %0d want 1000", on); end
    n = 0;
    while (in_ready === 1'b0 && n < 300) begin off++; n++; tick(0, 0, 3'd0); end
    checks++; if (off != 200) begin failures++; $display("FAIL holdoff_duration: got %0d want 200", off); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL after_holdoff_state: got %0d want 0", state); end
    checks++; if (svec !== ev(ms)) begin failures++; $display("FAIL full_cycle_short: got %h want %h", svec, ev(ms)); end
  endtask
  task automatic test_untrusted_abort();
    tick(1, 1, 3'b001); tick(1, 1, 3'b001);
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL abort_pre: got %0d want 1", state); end
    tick(1, 1, 3'b000);
    checks++; if ({err_flag, state} !== 3'b100) begin failures++; $display("FAIL abort_err: got err=%b st=%0d want err=1 st=0", err_flag, state); end
    tick(0, 0, 3'd0);
    checks++; if (err_flag !== 1'b0) begin failures++; $display("FAIL err_one_cycle: got %b want 0", err_flag); end
    for (int i = 0; i < 3; i++) tick(1, 1, 3'b001);
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL fresh_run3: got %0d want 1", state); end
    tick(1, 1, 3'b001);
    checks++; if ({valve_open, state, evt_count} !== {1'b1, 2'd2, 8'd2}) begin
      failures++; $display("FAIL fresh_run4: got v=%b st=%0d e=%0d want v=1 st=2 e=2", valve_open, state, evt_count); end
  endtask
  task automatic test_early_stop();
    int n = 0;
    repeat (9) tick(0, 0, 3'd0);
    checks++; if (valve_open !== 1'b1) begin failures++; $display("FAIL early_cycle9: got %b want 1", valve_open); end
    tick(1, 0, 3'b000);
    checks++; if ({valve_open, state} !== {1'b0, 2'd3}) begin
      failures++; $display("FAIL early_stop: got v=%b st=%0d want v=0 st=3", valve_open, state); end
    while (in_ready !== 1'b1 && n < 300) begin n++; tick(0, 0, 3'd0); end
    checks++; if (n != 200) begin failures++; $display("FAIL early_holdoff: got %0d want 200", n); end
  endtask
  task automatic test_adjacency();
    tick(1, 1, 3'b001);
    tick(1, 1, 3'b111);
`ifdef GRAY_ADJ_CHECK_EN
    checks++; if ({err_flag, state} !== 3'b100) begin failures++; $display("FAIL adjacency: got err=%b st=%0d want err=1 st=0", err_flag, state); end
`else
    checks++; if ({err_flag, state} !== 3'b001) begin failures++; $display("FAIL adjacency: got err=%b st=%0d want err=0 st=1", err_flag, state); end
    tick(1, 1, 3'b111); tick(1, 1, 3'b111);
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL adjacency_count: got %0d want 2", state); end
`endif
    checks++; if (dvec !== ev(m)) begin failures++; $display("FAIL adjacency_model: got %h want %h", dvec, ev(m)); end
  endtask
  task automatic test_reset_mid();
    apply_reset();
    repeat (4) tick(1, 1, 3'b001);
    repeat (49) tick(0, 0, 3'd0);
    checks++; if ({valve_open, state} !== 3'b110) begin failures++; $display("FAIL mid_pre: got v=%b st=%0d want v=1 st=2", valve_open, state); end
    #2 rst = 1'b1;
    #1;
    checks++; if (dvec !== 16'h4000) begin failures++; $display("FAIL async_reset: got %h want %h", dvec, 16'h4000); end
    checks++; if (svec !== 16'h4000) begin failures++; $display("FAIL async_reset_short: got %h want %h", svec, 16'h4000); end
    m = mreset(4, 1000, 200);
    ms = mreset(2, 3, 2);
    @(posedge clk); #1 rst = 1'b0;
  endtask
  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin
      int n = 0;
      while (ms.st != 2 && n < 10) begin n++; tick(1, 1, 3'b001); end
      while (ms.st != 0 && n < 30) begin n++; tick(0, 0, 3'd0); end
      checks++; if (svec !== ev(ms)) begin failures++; $display("FAIL saturate_iter%0d: got %h want %h", i, svec, ev(ms)); end
    end
    checks++; if (s_evt !== 8'd255) begin failures++; $display("FAIL saturate_cap: got %0d want 255", s_evt); end
    checks++; if (dvec !== ev(m)) begin failures++; $display("FAIL saturate_main: got %h want %h", dvec, ev(m)); end
  endtask
  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      int r = $urandom_range(0, 7);
      bit v = $urandom_range(0, 3) != 0;
      if (r < 5) tick(v, 1, 3'($urandom_range(1, 7)));
      else if (r == 5) tick(v, 0, 3'd0);
      else tick(v, 1'($urandom), 3'($urandom));
      checks++; if (dvec !== ev(m)) begin failures++; $display("FAIL random_main%0d: got %h want %h", i, dvec, ev(m)); end
      checks++; if (svec !== ev(ms)) begin failures++; $display("FAIL random_short%0d: got %h want %h", i, svec, ev(ms)); end
    end
  endtask
  initial begin
    test_reset();
    test_confirm();
    test_full_cycle();
    test_untrusted_abort();
    test_early_stop();
    test_adjacency();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
